irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Eight-source interrupt controller for a 6502 system: synchronizes the source lines, latches
// them by edge or level into PENDING, masks them with ENABLE, and drives irq_n and a priority vector.
module irq_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] src_n,
   input  logic       cs_n,
   input  logic       we,
   input  logic [2:0] reg_addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       irq_n,
   output logic [3:0] vector
);

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_PENDING = 3'd1;
   localparam logic [2:0] ADDR_ENABLE  = 3'd2;
   localparam logic [2:0] ADDR_EDGE    = 3'd3;
   localparam logic [2:0] ADDR_VECTOR  = 3'd4;
   localparam logic [2:0] ADDR_FORCE   = 3'd5;

   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] sync_prev;
   logic [7:0] pending;
   logic [7:0] enable;
   logic [7:0] edge_mode;

   logic       wr_en;
   logic [7:0] status;
   logic [7:0] fall;
   logic [7:0] active;
   logic [7:0] clr_mask;
   logic [7:0] force_mask;
   logic [7:0] mode_flip;
   logic [7:0] pending_nxt;
   logic [3:0] vector_nxt;

   assign wr_en      = ~cs_n & we;
   assign status     = ~sync_q[SYNC_STAGES-1];
   assign fall       = sync_prev & ~sync_q[SYNC_STAGES-1];
   assign active     = pending & enable;
   assign clr_mask   = (wr_en && reg_addr == ADDR_PENDING) ? wdata : 8'h00;
   assign force_mask = (wr_en && reg_addr == ADDR_FORCE) ? wdata : 8'h00;
   assign mode_flip  = (wr_en && reg_addr == ADDR_EDGE) ? (wdata ^ edge_mode) : 8'h00;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: synchronizer flops reset to 1 so a source never looks active straight out of reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'hFF;
         sync_prev <= 8'hFF;
      end else begin
         sync_q[0] <= src_n;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         sync_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   // NOTE: each always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pending_nxt = pending;
      for (int i = 0; i < 8; i++) begin
         if (mode_flip[i])
            pending_nxt[i] = 1'b0;
         else if (!edge_mode[i])
            pending_nxt[i] = status[i];
         else
            // New edge or software force beats a same-cycle W1C.
            pending_nxt[i] = fall[i] | force_mask[i] | (pending[i] & ~clr_mask[i]);
      end
   end

   // Ascending scan so the highest active bit overwrites lower ones.
   always_comb begin
      vector_nxt = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         if (active[i]) vector_nxt = {1'b1, 3'(i)};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending   <= 8'h00;
         enable    <= 8'h00;
         edge_mode <= 8'h00;
         irq_n     <= 1'b1;
         vector    <= 4'b0000;
      end else begin
         pending <= pending_nxt;
         if (wr_en && reg_addr == ADDR_ENABLE) enable <= wdata;
         if (wr_en && reg_addr == ADDR_EDGE) edge_mode <= wdata;
         irq_n  <= ~|active;
         vector <= vector_nxt;
      end
   end

   always_comb begin
      rdata = 8'h00;
      if (!cs_n) begin
         case (reg_addr)
            ADDR_STATUS:  rdata = status;
            ADDR_PENDING: rdata = pending;
            ADDR_ENABLE:  rdata = enable;
            ADDR_EDGE:    rdata = edge_mode;
            ADDR_VECTOR:  rdata = {4'b0000, vector};
            default:      rdata = 8'h00;
         endcase
      end
   end

endmodule
